// File: rtl/time_set_ctrl_pkg.sv
// Shared definitions for the time-setting front end, the hh:mm:ss counter and the display.
// The state encoding is also the value presented on the mode output.
package time_set_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_H  = 2'd1,
    SET_M  = 2'd2,
    COMMIT = 2'd3
  } state_e;

  localparam logic [4:0] HOURS_MAX = 5'd23;
  localparam logic [5:0] MINS_MAX  = 6'd59;

  // Wrap with explicit compares so 23/59 roll over, not the register width.
  function automatic logic [4:0] hour_step(input logic [4:0] val, input logic up);
    logic [4:0] res;
    if (up) res = (val == HOURS_MAX) ? 5'd0 : val + 5'd1;
    else    res = (val == 5'd0) ? HOURS_MAX : val - 5'd1;
    return res;
  endfunction

  function automatic logic [5:0] min_step(input logic [5:0] val, input logic up);
    logic [5:0] res;
    if (up) res = (val == MINS_MAX) ? 6'd0 : val + 6'd1;
    else    res = (val == 6'd0) ? MINS_MAX : val - 6'd1;
    return res;
  endfunction

endpackage

// File: rtl/time_set_ctrl_btn_debounce.sv
// One push-button channel: 2-FF synchroniser, stability counter and press pulse.
// press_o is high in the cycle whose clock edge moves the debounced level from 0 to 1.
module btn_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          db_q;
  logic [CW-1:0] cnt_q;
  logic          settle;

  // The synchronised level has differed from the debounced one long enough.
  assign settle  = (sync2_q != db_q) && (cnt_q == CNT_LAST);
  assign press_o = settle && sync2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      if (sync2_q == db_q) begin
        cnt_q <= '0;
      end else if (settle) begin
        db_q  <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Edit FSM in front of the hh:mm:ss counter: freezes it, edits hours then minutes,
// and commits with a one-cycle load pulse. mode exposes the FSM state directly.
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int CLK_HZ      = 100000000,
  parameter int DEBOUNCE_MS = 10,
  parameter int BLINK_HZ    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [4:0] cur_h,
  input  logic [5:0] cur_m,
  output logic       run_en,
  output logic       load,
  output logic [4:0] load_h,
  output logic [5:0] load_m,
  output logic [5:0] load_s,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int DB_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int BLINK_TOG = CLK_HZ / (2 * BLINK_HZ);
  localparam int BW        = (BLINK_TOG > 1) ? $clog2(BLINK_TOG) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TOG - 1);

  logic mode_p, up_p, down_p;
  logic adj_up, adj_dn;

  state_e        state_q;
  logic [4:0]    sh_h_q;
  logic [5:0]    sh_m_q;
  logic          run_en_q;
  logic          load_q;
  logic [4:0]    load_h_q;
  logic [5:0]    load_m_q;
  logic          blink_q;
  logic [BW-1:0] blink_cnt_q;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk(clk), .rst(rst), .btn_i(btn_mode), .press_o(mode_p));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk(clk), .rst(rst), .btn_i(btn_up), .press_o(up_p));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_down (
    .clk(clk), .rst(rst), .btn_i(btn_down), .press_o(down_p));

  // Coincident up and down cancel; mode has priority and is tested first below.
  assign adj_up = up_p && !down_p;
  assign adj_dn = down_p && !up_p;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      sh_h_q      <= '0;
      sh_m_q      <= '0;
      run_en_q    <= 1'b1;
      load_q      <= 1'b0;
      load_h_q    <= '0;
      load_m_q    <= '0;
      blink_q     <= 1'b1;
      blink_cnt_q <= '0;
    end else begin
      load_q <= 1'b0;
      if (state_q == SET_H || state_q == SET_M) begin
        if (blink_cnt_q == BLINK_LAST) begin
          blink_q     <= ~blink_q;
          blink_cnt_q <= '0;
        end else begin
          blink_cnt_q <= blink_cnt_q + 1'b1;
        end
      end else begin
        blink_q     <= 1'b1;
        blink_cnt_q <= '0;
      end

      case (state_q)
        RUN: begin
          if (mode_p) begin
            state_q     <= SET_H;
            run_en_q    <= 1'b0;
            sh_h_q      <= (cur_h > HOURS_MAX) ? 5'd0 : cur_h;
            sh_m_q      <= (cur_m > MINS_MAX) ? 6'd0 : cur_m;
            blink_q     <= 1'b1;
            blink_cnt_q <= '0;
          end
        end
        SET_H: begin
          if (mode_p) begin
            state_q     <= SET_M;
            blink_q     <= 1'b1;
            blink_cnt_q <= '0;
          end else if (adj_up) begin
            sh_h_q <= hour_step(sh_h_q, 1'b1);
          end else if (adj_dn) begin
            sh_h_q <= hour_step(sh_h_q, 1'b0);
          end
        end
        SET_M: begin
          if (mode_p) begin
            state_q  <= COMMIT;
            load_q   <= 1'b1;
            load_h_q <= sh_h_q;
            load_m_q <= sh_m_q;
            blink_q  <= 1'b1;
          end else if (adj_up) begin
            sh_m_q <= min_step(sh_m_q, 1'b1);
          end else if (adj_dn) begin
            sh_m_q <= min_step(sh_m_q, 1'b0);
          end
        end
        COMMIT: begin
          state_q  <= RUN;
          run_en_q <= 1'b1;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign run_en = run_en_q;
  assign load   = load_q;
  assign load_h = load_h_q;
  assign load_m = load_m_q;
  assign load_s = 6'd0;
  assign mode   = state_q;
  assign blink  = blink_q;

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Time-setting front end that sits directly upstream of the hh:mm:ss counter.
- Debounces three raw board push-buttons (mode, up, down).
- Runs an edit FSM that freezes the counter and lets the user adjust hours, then minutes.
- Commits the edited time to the counter with a one-cycle load pulse.
- Provides a blink strobe so the display stage can flash the field being edited.

Parameters:
CLK_HZ, 100000000, input clock frequency in Hz
DEBOUNCE_MS, 10, time a button level must be stable before it is accepted; DB_CYCLES = CLK_HZ/1000*DEBOUNCE_MS
BLINK_HZ, 2, blink frequency while editing; blink toggles every CLK_HZ/(2*BLINK_HZ) cycles

Ports:
clk  in  1  system clock (single clock domain)
rst  in  1  asynchronous, active-low reset
btn_mode  in  1  raw mode button, asynchronous, active-high
btn_up  in  1  raw increment button, asynchronous, active-high
btn_down  in  1  raw decrement button, asynchronous, active-high
cur_h  in  5  current hours from the clock counter
cur_m  in  6  current minutes from the clock counter
run_en  out  1  counter count-enable; 1 only in RUN
load  out  1  one-cycle pulse: counter loads load_h/load_m/load_s
load_h  out  5  hours to load, 0..23
load_m  out  6  minutes to load, 0..59
load_s  out  6  seconds to load; always 0
mode  out  2  0=RUN, 1=SET_H, 2=SET_M, 3=COMMIT
blink  out  1  display flash strobe for the edited field

Behaviour:
Reset (rst=0, asynchronous) values:
- state RUN, run_en=1, load=0, load_h=0, load_m=0, load_s=0, blink=1.
- Shadow registers sh_h and sh_m = 0.
- Synchronisers, debounced levels and all counters = 0.

Button path (identical for each button):
- 2-FF synchroniser.
- Debounce counter clears whenever the synchronised level equals the debounced level.
- Otherwise the counter increments; on reaching DB_CYCLES-1 the debounced level takes the synchronised level and the counter clears.
- A 0->1 change of the debounced level produces a one-cycle press pulse.
- Latency from a clean raw edge to the press pulse: 2 + DB_CYCLES cycles.
- Glitches shorter than DB_CYCLES cycles produce no pulse.
- Release edges produce no pulse.

FSM, evaluated on press pulses:
- RUN:
  - mode press -> SET_H.
  - sh_h <= cur_h, with cur_h > 23 captured as 0.
  - sh_m <= cur_m, with cur_m > 59 captured as 0.
  - up/down presses ignored.
- SET_H:
  - up press: sh_h = (sh_h==23) ? 0 : sh_h+1.
  - down press: sh_h = (sh_h==0) ? 23 : sh_h-1.
  - mode press -> SET_M.
- SET_M:
  - up/down wrap 59<->0 the same way.
  - mode press -> COMMIT.
- COMMIT (exactly one cycle, unconditional):
  - load=1, load_h=sh_h, load_m=sh_m, load_s=0.
  - next state RUN.
- run_en is 0 in SET_H, SET_M and COMMIT, so the counter is frozen during edit and in the load cycle.
- run_en returns to 1 the cycle after load.
- load_h/load_m hold their last committed values between commits.

Simultaneous events:
- up and down pressed in the same cycle: both ignored.
- mode with up or down in the same cycle: mode wins, and the adjust is dropped.

Blink:
- Forced to 1 in RUN.
- On entry to SET_H or SET_M: blink=1 and the blink counter clears.
- Thereafter blink toggles every CLK_HZ/(2*BLINK_HZ) cycles.

Reset mid-edit:
- Shadow values are discarded and no load pulse is issued.
- After release the FSM starts in RUN with run_en=1.

Width rules:
- All adjustments use explicit wrap compares, never modular overflow of the register width.
- sh_h is 5 bits; sh_m is 6 bits.

Decomposition:
- Shared package:
  - State enum RUN/SET_H/SET_M/COMMIT, matching the mode encoding.
  - Constants HOURS_MAX=23 and MINS_MAX=59, also reused by the counter and display stages.
- One sub-module, btn_debounce (parameter DB_CYCLES), containing synchroniser, debounce counter and press-pulse generator; instantiated three times.
- The FSM, shadow registers and blink generator live in time_set_ctrl.

Test Plan:
Bench parameters: CLK_HZ=1000, DEBOUNCE_MS=4 (DB_CYCLES=4), BLINK_HZ=50 (toggle every 10 cycles).
1. Reset: hold rst=0 while toggling buttons -> run_en=1, load=0, mode=0, blink=1. Release rst -> no press pulse and no state change.
2. Debounce: btn_mode high for 3 cycles -> mode stays 0. btn_mode high for 20 cycles -> mode becomes 1 exactly 6 cycles after the raw edge; run_en=0.
3. Hour wrap: cur_h=23, cur_m=59; enter SET_H; 1 up press -> sh_h=0; 2 down presses -> sh_h=22.
4. Commit: enter SET_M, down from 59 -> 58, then mode press -> mode 2->3. load=1 for exactly one cycle with load_h=22, load_m=58, load_s=0. Next cycle mode=0, run_en=1, load=0.
5. Simultaneous: up and down press pulses coincide -> sh_h unchanged. mode and up coincide in SET_H -> mode=2, sh_h unchanged.
6. Reset mid-edit: in SET_M with edited values, assert rst=0 for 1 cycle -> no load pulse ever, mode=0, run_en=1, blink=1. Also check blink toggles at a 10-cycle period in SET_H and is restarted at 1 on entering SET_M.
